// File: rtl/instruction_fetch.sv
// Fetch stage: holds the PC, drives the ROM address and registers the returned word.
// Optional fetch/flush performance counters are compiled in with FETCH_PERF_EN.
module instruction_fetch #(
    parameter int                  ADDR_W       = 16,
    parameter int                  INSTR_W      = 28,
    parameter logic [ADDR_W-1:0]   RESET_VECTOR = '0,
    parameter logic [INSTR_W-1:0]  NOP_WORD     = '0
) (
    input  logic               Clock,
    input  logic               Reset,
    input  logic               iEnable,
    input  logic               iStall,
    input  logic               iRedirect,
    input  logic [ADDR_W-1:0]  iRedirectAddr,
    output logic [ADDR_W-1:0]  oAddress,
    input  logic [INSTR_W-1:0] iInstruction,
    output logic [INSTR_W-1:0] oInstruction,
    output logic [ADDR_W-1:0]  oInstrPC,
    output logic               oValid
`ifdef FETCH_PERF_EN
    ,
    output logic [15:0]        oFetchCount,
    output logic [15:0]        oFlushCount
`endif
);

    typedef enum logic [1:0] {IDLE, RUN, FLUSH} state_t;

    typedef struct packed {
        logic [INSTR_W-1:0] instr;
        logic [ADDR_W-1:0]  pc;
        logic               vld;
    } ir_t;

    state_t            state, state_nx;
    logic [ADDR_W-1:0] pc, pc_nx;
    ir_t               ir;
    logic              latch, redir, drop;

    assign oAddress     = pc;
    assign oInstruction = ir.instr;
    assign oInstrPC     = ir.pc;
    assign oValid       = ir.vld;

    // RUN and FLUSH share one priority chain: redirect, stall, disable, fetch.
    always_comb begin
        state_nx = state;
        pc_nx    = pc;
        latch    = 1'b0;
        redir    = 1'b0;
        drop     = 1'b0;
        case (state)
            IDLE: if (iEnable) state_nx = RUN;
            RUN, FLUSH: begin
                if (iRedirect) begin
                    redir    = 1'b1;
                    pc_nx    = iRedirectAddr;
                    state_nx = FLUSH;
                end else if (iStall) begin
                    state_nx = state;
                end else if (!iEnable) begin
                    drop     = 1'b1;
                    state_nx = IDLE;
                end else begin
                    latch    = 1'b1;
                    pc_nx    = pc + ADDR_W'(1);
                    state_nx = RUN;
                end
            end
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge Clock or negedge Reset) begin
        if (!Reset) begin
            state <= IDLE;
            pc    <= RESET_VECTOR;
        end else begin
            state <= state_nx;
            pc    <= pc_nx;
        end
    end

    always_ff @(posedge Clock or negedge Reset) begin
        if (!Reset) begin
            ir.instr <= NOP_WORD;
            ir.pc    <= '0;
            ir.vld   <= 1'b0;
        end else if (redir) begin
            ir.instr <= NOP_WORD;
            ir.vld   <= 1'b0;
        end else if (drop) begin
            ir.vld   <= 1'b0;
        end else if (latch) begin
            ir.instr <= iInstruction;
            ir.pc    <= pc;
            ir.vld   <= 1'b1;
        end
    end

`ifdef FETCH_PERF_EN
    always_ff @(posedge Clock or negedge Reset) begin
        if (!Reset) begin
            oFetchCount <= '0;
            oFlushCount <= '0;
        end else begin
            if (latch && oFetchCount != 16'hFFFF) oFetchCount <= oFetchCount + 16'd1;
            if (redir && oFlushCount != 16'hFFFF) oFlushCount <= oFlushCount + 16'd1;
        end
    end
`endif

endmodule

// File: tb/tb_instruction_fetch.sv
// Directed bench for instruction_fetch: run, stall, redirect, redirect+stall, wrap, disable, reset.
// Counter checks are compiled in when FETCH_PERF_EN is defined.
module tb_instruction_fetch;

    logic        Clock = 1'b0;
    logic        Reset, en, stall, redir;
    logic [15:0] raddr;
    logic [15:0] addr, ipc;
    logic [27:0] rom, instr;
    logic        vld;

    logic        w_rst, w_en;
    logic        w_stall = 1'b0, w_redir = 1'b0;
    logic [15:0] w_raddr = 16'd0;
    logic [15:0] w_addr, w_ipc;
    logic [27:0] w_rom, w_instr;
    logic        w_vld;

`ifdef FETCH_PERF_EN
    logic [15:0] fcnt, flcnt, w_fcnt, w_flcnt;
`endif

    int checks = 0;
    int failures = 0;

    always #5 Clock = ~Clock;

    // ROM returns a tagged copy of its address so a real word never equals NOP.
    assign rom   = {12'hABC, addr};
    assign w_rom = {12'hABC, w_addr};

    instruction_fetch dut (
        .Clock(Clock), .Reset(Reset), .iEnable(en), .iStall(stall),
        .iRedirect(redir), .iRedirectAddr(raddr), .oAddress(addr),
        .iInstruction(rom), .oInstruction(instr), .oInstrPC(ipc), .oValid(vld)
`ifdef FETCH_PERF_EN
        , .oFetchCount(fcnt), .oFlushCount(flcnt)
`endif
    );

    instruction_fetch #(.RESET_VECTOR(16'hFFFE)) dut_w (
        .Clock(Clock), .Reset(w_rst), .iEnable(w_en), .iStall(w_stall),
        .iRedirect(w_redir), .iRedirectAddr(w_raddr), .oAddress(w_addr),
        .iInstruction(w_rom), .oInstruction(w_instr), .oInstrPC(w_ipc), .oValid(w_vld)
`ifdef FETCH_PERF_EN
        , .oFetchCount(w_fcnt), .oFlushCount(w_flcnt)
`endif
    );

    task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h", tag, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge Clock);
        #1;
    endtask

    // Expect a valid instruction fetched from address a, with PC now at n.
    task automatic expect_fetch(input string tag, input logic [15:0] a, input logic [15:0] n);
        chk({tag, ".vld"}, 32'(vld), 32'd1);
        chk({tag, ".ipc"}, 32'(ipc), 32'(a));
        chk({tag, ".ins"}, 32'(instr), 32'({12'hABC, a}));
        chk({tag, ".adr"}, 32'(addr), 32'(n));
    endtask

    initial begin
        Reset = 1'b0; en = 1'b0; stall = 1'b0; redir = 1'b0; raddr = 16'd0;
        w_rst = 1'b0; w_en = 1'b0;
        #12;
        chk("rst.adr", 32'(addr), 32'd0);
        chk("rst.vld", 32'(vld), 32'd0);
        chk("rst.ins", 32'(instr), 32'd0);
        chk("rst.ipc", 32'(ipc), 32'd0);
        chk("rstw.adr", 32'(w_addr), 32'hFFFE);

        Reset = 1'b1;
        tick();
        chk("idle.adr", 32'(addr), 32'd0);
        chk("idle.vld", 32'(vld), 32'd0);

        en = 1'b1;
        tick();
        chk("enter.vld", 32'(vld), 32'd0);
        chk("enter.adr", 32'(addr), 32'd0);
        for (int i = 0; i < 5; i++) begin
            tick();
            expect_fetch("run", 16'(i), 16'(i + 1));
        end

        stall = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick();
            expect_fetch("stall", 16'd4, 16'd5);
        end
        stall = 1'b0;
        for (int i = 5; i < 11; i++) begin
            tick();
            expect_fetch("resume", 16'(i), 16'(i + 1));
        end

        redir = 1'b1; raddr = 16'd8;
        tick();
        redir = 1'b0;
        chk("redir.vld", 32'(vld), 32'd0);
        chk("redir.ins", 32'(instr), 32'd0);
        chk("redir.adr", 32'(addr), 32'd8);
        tick();
        expect_fetch("post8", 16'd8, 16'd9);
        tick();
        expect_fetch("post9", 16'd9, 16'd10);

        redir = 1'b1; raddr = 16'd2;
        tick();
        redir = 1'b0;
        tick();
        expect_fetch("pc3", 16'd2, 16'd3);
        redir = 1'b1; stall = 1'b1; raddr = 16'd2;
        tick();
        redir = 1'b0;
        chk("rs.vld", 32'(vld), 32'd0);
        chk("rs.adr", 32'(addr), 32'd2);
        chk("rs.ins", 32'(instr), 32'd0);
        for (int i = 0; i < 2; i++) begin
            tick();
            chk("fstall.vld", 32'(vld), 32'd0);
            chk("fstall.adr", 32'(addr), 32'd2);
        end
        stall = 1'b0;
        tick();
        expect_fetch("frel", 16'd2, 16'd3);
        for (int i = 3; i < 7; i++) begin
            tick();
            expect_fetch("to7", 16'(i), 16'(i + 1));
        end

        #2 Reset = 1'b0;
        #1;
        chk("arst.adr", 32'(addr), 32'd0);
        chk("arst.vld", 32'(vld), 32'd0);
        chk("arst.ipc", 32'(ipc), 32'd0);
        chk("arst.ins", 32'(instr), 32'd0);
`ifdef FETCH_PERF_EN
        chk("arst.fcnt", 32'(fcnt), 32'd0);
        chk("arst.flcnt", 32'(flcnt), 32'd0);
`endif
        @(negedge Clock);
        Reset = 1'b1;
        tick();
        chk("reidle.vld", 32'(vld), 32'd0);
        for (int i = 0; i < 3; i++) begin
            tick();
            expect_fetch("refetch", 16'(i), 16'(i + 1));
        end
        redir = 1'b1; raddr = 16'd20;
        tick();
        redir = 1'b0;
        chk("redir20.adr", 32'(addr), 32'd20);
        chk("redir20.vld", 32'(vld), 32'd0);
`ifdef FETCH_PERF_EN
        chk("perf.fcnt", 32'(fcnt), 32'd3);
        chk("perf.flcnt", 32'(flcnt), 32'd1);
`endif

        w_rst = 1'b1; w_en = 1'b1;
        tick();
        chk("wrap.enter", 32'(w_vld), 32'd0);
        tick();
        chk("wrap.ipc0", 32'(w_ipc), 32'hFFFE);
        tick();
        chk("wrap.ipc1", 32'(w_ipc), 32'hFFFF);
        chk("wrap.adr1", 32'(w_addr), 32'h0000);
        tick();
        chk("wrap.ipc2", 32'(w_ipc), 32'h0000);
        chk("wrap.ins2", 32'(w_instr), 32'hABC0000);
        chk("wrap.vld2", 32'(w_vld), 32'd1);
        w_en = 1'b0;
        tick();
        chk("dis.vld", 32'(w_vld), 32'd0);
        chk("dis.adr", 32'(w_addr), 32'h0001);
        tick();
        chk("dis.hold", 32'(w_addr), 32'h0001);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/instruction_fetch.md
Name: instruction_fetch

Overview:
Fetch stage sitting directly upstream of the combinational instruction ROM and feeding the decode/execute stage. It holds the program counter and drives the ROM address. It latches the returned 28-bit instruction into a registered instruction/PC pair with a valid flag. It also handles stall and branch/jump redirect with a one-slot flush.

Parameters:
RESET_VECTOR, 16'd0, PC value loaded on reset
ADDR_W, 16, PC / ROM address width
INSTR_W, 28, instruction width
NOP_WORD, 28'd0, value presented on oInstruction when no valid instruction is held

Ports:
Clock  input  1  system clock, rising edge
Reset  input  1  asynchronous, active-low reset
iEnable  input  1  1 = fetching permitted; 0 = hold in IDLE
iStall  input  1  downstream not ready; hold PC and IR
iRedirect  input  1  branch taken / jump from execute, single-cycle pulse
iRedirectAddr  input  ADDR_W  redirect target
oAddress  output  ADDR_W  ROM address, equals PC register (combinational from the register)
iInstruction  input  INSTR_W  ROM data, valid in the same cycle as oAddress
oInstruction  output  INSTR_W  registered instruction to decode
oInstrPC  output  ADDR_W  address of oInstruction
oValid  output  1  oInstruction is a real fetched instruction

Behaviour:
- Reset (Reset=0, asynchronous):
  - PC=RESET_VECTOR, oInstruction=NOP_WORD, oInstrPC=0, oValid=0, state=IDLE.
- States: IDLE, RUN, FLUSH.
- IDLE:
  - PC held; oValid=0.
  - iEnable=1 -> RUN next cycle. Nothing is latched in the transition cycle.
- RUN, each rising edge, priority order:
  1. iRedirect=1 (wins over iStall): PC<=iRedirectAddr, oValid<=0, oInstruction<=NOP_WORD, state<=FLUSH.
  2. iStall=1: PC, oInstruction, oInstrPC, oValid all held.
  3. Otherwise: oInstruction<=iInstruction, oInstrPC<=PC, oValid<=1, PC<=PC+1.
- FLUSH:
  - Exactly one cycle. The ROM is addressed with the redirect target; oValid stays 0.
  - Next edge: if iStall=0, latch as in RUN and go to RUN. If iStall=1, hold, remain in FLUSH.
  - A redirect in FLUSH reloads the PC and stays in FLUSH.
- iEnable=0 in RUN or FLUSH:
  - If no stall: oValid<=0, PC held, state<=IDLE. The instruction in flight is not latched.
  - Redirect still has priority and loads the PC.
- PC arithmetic: unsigned ADDR_W bits; 16'hFFFF+1 wraps to 16'h0000 with no flag.
- Latency: an address presented in cycle n appears on oInstruction with oValid=1 after edge n+1 (one cycle).
- A redirect bubble costs exactly one cycle of oValid=0.
- Reset asserted mid-operation: immediate return to reset values. Any pending redirect is lost.

Optional Feature:
- Macro: FETCH_PERF_EN.
- Defined adds two outputs:
  - oFetchCount [15:0]: increments on every edge that sets oValid<=1.
  - oFlushCount [15:0]: increments on every accepted redirect.
  - Both saturate at 16'hFFFF and reset to 0.
- Undefined: the ports and counters do not exist; the remaining behaviour is identical.

Test Plan:
- Reset release, iEnable=1, no stall, ROM word = address -> oAddress 0,1,2,…; oValid rises one cycle after RUN; oInstrPC/oInstruction 0,1,2 in successive cycles.
- iStall held 3 cycles at PC=5 -> oAddress stays 5; oInstruction/oInstrPC/oValid frozen; resumes at 5 once released.
- iRedirect with iRedirectAddr=8 while PC=11 -> one cycle oValid=0, oInstruction=NOP_WORD; then oInstrPC=8, then 9.
- iRedirect and iStall together at PC=3, target 2 -> redirect wins: PC=2, FLUSH; stall held in FLUSH keeps oValid=0 until released.
- RESET_VECTOR=16'hFFFE, run -> oInstrPC FFFE, FFFF, 0000 (wrap).
- Reset pulsed low mid-run at PC=7 -> asynchronous clear to PC=RESET_VECTOR, oValid=0, IDLE. With FETCH_PERF_EN: counters read 0, then count 3 fetches and 1 flush correctly.
